// File: rtl/ahblite_master_arbiter.sv
// ahblite_master_arbiter: two-master AHB-Lite arbiter (M0 core, M1 DMA) onto one shared bus.
// Ports: HCLK/HRESETn clock and async active-low reset; H*_M0/H*_M1 master address/control/write
// data in, HRDATA_Mx/HREADY_Mx/HRESP_Mx per-master response out; HADDR..HWDATA shared bus out,
// HMASTER address-phase owner out; HRDATA/HREADY/HRESP shared bus response in.
// Build option: define AHB_ARB_LOCK_EN to keep the grant on an owner while its HMASTLOCK is high.
// A master losing arbitration has its address phase captured in a hold register and is stalled
// through HREADY_Mx until the held transfer has been issued on the shared bus.
module ahblite_master_arbiter #(
    parameter bit PARK_MASTER = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR_M0,
    input  logic [1:0]  HTRANS_M0,
    input  logic        HWRITE_M0,
    input  logic [2:0]  HSIZE_M0,
    input  logic [2:0]  HBURST_M0,
    input  logic [3:0]  HPROT_M0,
    input  logic        HMASTLOCK_M0,
    input  logic [31:0] HWDATA_M0,
    output logic [31:0] HRDATA_M0,
    output logic        HREADY_M0,
    output logic        HRESP_M0,
    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M1,
    input  logic [2:0]  HSIZE_M1,
    input  logic [2:0]  HBURST_M1,
    input  logic [3:0]  HPROT_M1,
    input  logic        HMASTLOCK_M1,
    input  logic [31:0] HWDATA_M1,
    output logic [31:0] HRDATA_M1,
    output logic        HREADY_M1,
    output logic        HRESP_M1,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    output logic        HMASTER,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);
    localparam logic [1:0] TR_IDLE = 2'b00;

    logic [31:0] w_addr  [2];
    logic [1:0]  w_trans [2];
    logic        w_write [2];
    logic [2:0]  w_size  [2];
    logic [2:0]  w_burst [2];
    logic [3:0]  w_prot  [2];
    logic        w_lock  [2];

    logic [31:0] r_h_addr  [2];
    logic [1:0]  r_h_trans [2];
    logic        r_h_write [2];
    logic [2:0]  r_h_size  [2];
    logic [2:0]  r_h_burst [2];
    logic [3:0]  r_h_prot  [2];
    logic        r_h_lock  [2];

    logic [31:0] w_e_addr  [2];
    logic [1:0]  w_e_trans [2];
    logic        w_e_write [2];
    logic [2:0]  w_e_size  [2];
    logic [2:0]  w_e_burst [2];
    logic [3:0]  w_e_prot  [2];
    logic        w_e_lock  [2];

    logic        r_gnt;
    logic        r_dph_valid;
    logic        r_dph_owner;
    logic [1:0]  r_hold_valid;

    logic [1:0]  w_req;
    logic [1:0]  w_dph_mine;
    logic [1:0]  w_hrdy;
    logic [1:0]  w_hrsp;
    logic [1:0]  w_cap;
    logic [1:0]  w_clr;
    logic        w_keep;
    logic        w_next;
    logic        w_owner;

    assign w_addr[0]  = HADDR_M0;
    assign w_addr[1]  = HADDR_M1;
    assign w_trans[0] = HTRANS_M0;
    assign w_trans[1] = HTRANS_M1;
    assign w_write[0] = HWRITE_M0;
    assign w_write[1] = HWRITE_M1;
    assign w_size[0]  = HSIZE_M0;
    assign w_size[1]  = HSIZE_M1;
    assign w_burst[0] = HBURST_M0;
    assign w_burst[1] = HBURST_M1;
    assign w_prot[0]  = HPROT_M0;
    assign w_prot[1]  = HPROT_M1;
    assign w_lock[0]  = HMASTLOCK_M0;
    assign w_lock[1]  = HMASTLOCK_M1;

    genvar i;
    generate
        for (i = 0; i < 2; i++) begin : g_m
            assign w_e_addr[i]  = r_hold_valid[i] ? r_h_addr[i]  : w_addr[i];
            assign w_e_trans[i] = r_hold_valid[i] ? r_h_trans[i] : w_trans[i];
            assign w_e_write[i] = r_hold_valid[i] ? r_h_write[i] : w_write[i];
            assign w_e_size[i]  = r_hold_valid[i] ? r_h_size[i]  : w_size[i];
            assign w_e_burst[i] = r_hold_valid[i] ? r_h_burst[i] : w_burst[i];
            assign w_e_prot[i]  = r_hold_valid[i] ? r_h_prot[i]  : w_prot[i];
            assign w_e_lock[i]  = r_hold_valid[i] ? r_h_lock[i]  : w_lock[i];
            // a held transfer is always NONSEQ, so bit 1 of the effective HTRANS covers both request sources
            assign w_req[i]      = w_e_trans[i][1];
            assign w_dph_mine[i] = r_dph_valid && (r_dph_owner == 1'(i));
            assign w_hrdy[i]     = w_dph_mine[i] ? HREADY : ~r_hold_valid[i];
            assign w_hrsp[i]     = w_dph_mine[i] & HRESP;
            // a losing master that sees HREADY_Mx=1 believes its address phase was taken, so park it here
            assign w_cap[i]      = (w_owner != 1'(i)) & w_trans[i][1] & w_hrdy[i] & ~r_hold_valid[i];
            assign w_clr[i]      = r_hold_valid[i] & (w_owner == 1'(i)) & HREADY;
        end
    endgenerate

    // r_gnt is the owner of the last arbitration; the decision taken at an HREADY=1 cycle already
    // drives that cycle's address phase so an uncontended master sees no added latency.
    always_comb begin
        w_keep = w_e_trans[r_gnt][0];
`ifdef AHB_ARB_LOCK_EN
        w_keep = w_keep | w_e_lock[r_gnt];
`endif
        w_next = w_keep ? r_gnt :
                 (w_req == 2'b11) ? ~r_gnt :
                 w_req[0] ? 1'b0 :
                 w_req[1] ? 1'b1 : PARK_MASTER;
        w_owner = HREADY ? w_next : r_gnt;
    end

    assign HADDR     = w_e_addr[w_owner];
    assign HTRANS    = HRESETn ? w_e_trans[w_owner] : TR_IDLE;
    assign HWRITE    = w_e_write[w_owner];
    assign HSIZE     = w_e_size[w_owner];
    assign HBURST    = w_e_burst[w_owner];
    assign HPROT     = w_e_prot[w_owner];
    assign HMASTLOCK = w_e_lock[w_owner];
    assign HMASTER   = w_owner;
    assign HWDATA    = r_dph_owner ? HWDATA_M1 : HWDATA_M0;
    assign HRDATA_M0 = HRDATA;
    assign HRDATA_M1 = HRDATA;
    assign HREADY_M0 = w_hrdy[0];
    assign HREADY_M1 = w_hrdy[1];
    assign HRESP_M0  = w_hrsp[0];
    assign HRESP_M1  = w_hrsp[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_gnt        <= PARK_MASTER;
            r_dph_valid  <= 1'b0;
            r_dph_owner  <= PARK_MASTER;
            r_hold_valid <= '0;
        end else begin
            if (HREADY) begin
                r_gnt       <= w_next;
                r_dph_valid <= HTRANS[1];
                r_dph_owner <= w_owner;
            end
            r_hold_valid <= (r_hold_valid | w_cap) & ~w_clr;
        end
    end

    always_ff @(posedge HCLK) begin
        for (int k = 0; k < 2; k++) begin
            if (w_cap[k]) begin
                r_h_addr[k]  <= w_addr[k];
                r_h_trans[k] <= w_trans[k];
                r_h_write[k] <= w_write[k];
                r_h_size[k]  <= w_size[k];
                r_h_burst[k] <= w_burst[k];
                r_h_prot[k]  <= w_prot[k];
                r_h_lock[k]  <= w_lock[k];
            end
        end
    end
endmodule
